aud_i2s_tx: RTL and testbench



---
 rtl/aud_pkg.sv | 17 +
 rtl/aud_i2s_tx_bclk_gen.sv | 35 +++
 rtl/aud_i2s_tx.sv | 113 +++++++++++
 tb/tb_aud_i2s_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared audio definitions: default sample width, channel select and I2S
// transmitter state encodings.
package aud_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/aud_i2s_tx_bclk_gen.sv
// Bit clock generator: divides i_clk down to BCLK and flags the i_clk cycle
// whose closing edge makes BCLK rise or fall.
module bclk_gen #(
  parameter int BCLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             term;

  // Strobes are decoded, not registered, so the parent can update its own
  // registers on the very edge that moves BCLK.
  assign term   = (div == DIV_LAST);
  assign o_rise = term && !o_bclk;
  assign o_fall = term && o_bclk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div    <= '0;
      o_bclk <= 1'b0;
    end else begin
      div <= term ? '0 : div + DIV_W'(1);
      if (term) o_bclk <= !o_bclk;
    end
  end

endmodule

// File: rtl/aud_i2s_tx.sv
// Codec-side I2S transmitter: buffers one stereo pair and serialises it as
// one I2S frame (left then right, MSB first, one BCLK delay slot per half).
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int BITS_PER_CH = 32,
  parameter int BCLK_DIV    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_left,
  input  logic [SAMPLE_W-1:0] i_right,
  output logic                o_ready,
  output logic                o_bclk,
  output logic                o_lrck,
  output logic                o_dat,
  output logic                o_underrun
);

  localparam int SLOT_W = $clog2(2 * BITS_PER_CH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * BITS_PER_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(BITS_PER_CH);

  tx_state_e           state, state_nxt;
  logic                bclk_rise, bclk_fall;
  logic                accept, dat_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt, k;
  ch_e                 ch_nxt;
  logic [SAMPLE_W-1:0] buf_l, buf_r, sh_l, sh_r, sh_sel;

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_bclk (o_bclk),
    .o_rise (bclk_rise),
    .o_fall (bclk_fall)
  );

  // Handshake: a pair transfers on any cycle with i_valid && o_ready; o_ready
  // is high exactly while the one-entry buffer is empty.
  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN:  state_nxt = S_RUN;
    endcase
  end

  // Data for the slot being entered: k = 0 is the I2S delay bit, then the
  // sample MSB first, then zero padding.
  always_comb begin
    slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
    ch_nxt   = (slot_nxt >= SLOT_HALF) ? CH_RIGHT : CH_LEFT;
    k        = (ch_nxt == CH_RIGHT) ? slot_nxt - SLOT_HALF : slot_nxt;
    sh_sel   = (ch_nxt == CH_RIGHT) ? sh_r : sh_l;
    dat_nxt  = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (int'(k) == SAMPLE_W - i) dat_nxt = sh_sel[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot       <= SLOT_LAST;
      o_lrck     <= 1'b1;
      o_dat      <= 1'b0;
      o_ready    <= 1'b1;
      o_underrun <= 1'b0;
      buf_l      <= '0;
      buf_r      <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
    end else begin
      o_underrun <= 1'b0;
      if (accept) begin
        buf_l   <= i_left;
        buf_r   <= i_right;
        o_ready <= 1'b0;
      end
      if (bclk_fall) begin
        slot   <= slot_nxt;
        o_lrck <= (ch_nxt == CH_RIGHT);
        o_dat  <= dat_nxt;
        // Frame load: an accept landing on this same edge still sees the
        // buffer as empty and waits for the next frame.
        if (slot == SLOT_LAST) begin
          if (!o_ready) begin
            sh_l    <= buf_l;
            sh_r    <= buf_r;
            o_ready <= 1'b1;
          end else begin
            sh_l       <= '0;
            sh_r       <= '0;
            o_underrun <= (state == S_RUN);
          end
        end
      end
    end
  end

  // Rise and fall come from a single toggle and can never coincide.
  assert property (@(posedge i_clk) disable iff (i_rst) !(bclk_rise && bclk_fall));

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Bench for aud_i2s_tx: directed stimulus pushes expected frames into a
// queue; a monitor reassembles each transmitted frame and compares it.
module tb_aud_i2s_tx;

  logic        clk = 1'b0;
  logic        rst1, v1, rdy1, bclk1, lrck1, dat1, ur1;
  logic [15:0] l1, r1;
  logic        rst2, v2, rdy2, bclk2, lrck2, dat2, ur2;
  logic [15:0] l2, r2;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [64:0] exp_q[$];

  logic [7:0]  exp_b = 8'b0110_0110;
  logic [7:0]  exp_l = 8'b0000_0111;
  logic [15:0] pl[5] = '{16'hA5C3, 16'h1357, 16'hFFFF, 16'h0001, 16'h8000};
  logic [15:0] pr[5] = '{16'h8001, 16'h2468, 16'h0000, 16'h7FFF, 16'hC3A5};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms");
    $fatal(1, "watchdog");
  end

  aud_i2s_tx u_dut (
    .i_clk      (clk),
    .i_rst      (rst1),
    .i_valid    (v1),
    .i_left     (l1),
    .i_right    (r1),
    .o_ready    (rdy1),
    .o_bclk     (bclk1),
    .o_lrck     (lrck1),
    .o_dat      (dat1),
    .o_underrun (ur1)
  );

  aud_i2s_tx #(.SAMPLE_W(16), .BITS_PER_CH(17), .BCLK_DIV(1)) u_dut2 (
    .i_clk      (clk),
    .i_rst      (rst2),
    .i_valid    (v2),
    .i_left     (l2),
    .i_right    (r2),
    .o_ready    (rdy2),
    .o_bclk     (bclk2),
    .o_lrck     (lrck2),
    .o_dat      (dat2),
    .o_underrun (ur2)
  );

  // {underrun at load, slot 0 .. slot 63 as bit 63 .. bit 0}
  function automatic logic [64:0] mk_frame(input logic ur, input logic [15:0] l,
                                           input logic [15:0] r);
    return {ur, 1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    chk(nm, 65'(act), 65'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_load(input string nm);
    int   n;
    logic prev;
    n = 0;
    do begin
      prev = lrck1;
      @(negedge clk);
      n++;
    end while (!(prev && !lrck1) && n < 400);
    if (!(prev && !lrck1)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no frame load in 400 cycles, want one", nm);
    end
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d frames outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        mon_bclk_q, mon_lrck_q, mon_in_frame, mon_ur, mon_load;
  logic [63:0] mon_sh;
  int          mon_bits;
  int          mon_frame = 0;

  always @(negedge clk) begin
    if (rst1) begin
      mon_bclk_q   = 1'b0;
      mon_lrck_q   = 1'b1;
      mon_in_frame = 1'b0;
      mon_bits     = 0;
    end else begin
      mon_load = mon_lrck_q && !lrck1;
      if (ur1 && !mon_load) chk_bit("underrun_outside_load", ur1, 1'b0);
      if (bclk1 && !mon_bclk_q && mon_in_frame) begin
        mon_sh = {mon_sh[62:0], dat1};
        mon_bits++;
        if (mon_bits == 64) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame%0d: got %h, want no frame", mon_frame, {mon_ur, mon_sh});
          end else begin
            chk($sformatf("frame%0d", mon_frame), {mon_ur, mon_sh}, exp_q.pop_front());
          end
          mon_frame++;
          mon_in_frame = 1'b0;
        end
      end
      if (mon_load) begin
        mon_in_frame = 1'b1;
        mon_bits     = 0;
        mon_ur       = ur1;
      end
      mon_bclk_q = bclk1;
      mon_lrck_q = lrck1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   n, cyc;
    logic prev;
    rst1 = 1'b1; v1 = 1'b0; l1 = '0; r1 = '0;
    rst2 = 1'b1; v2 = 1'b0; l2 = '0; r2 = '0;
    repeat (3) @(negedge clk);

    chk_bit("rst_bclk", bclk1, 1'b0);
    chk_bit("rst_lrck", lrck1, 1'b1);
    chk_bit("rst_dat", dat1, 1'b0);
    chk_bit("rst_ready", rdy1, 1'b1);
    chk_bit("rst_underrun", ur1, 1'b0);

    // Small configuration: reset in the middle of the right channel.
    rst2 = 1'b0; v2 = 1'b1; l2 = 16'h1234; r2 = 16'h5678;
    @(posedge clk); @(negedge clk);
    l2 = 16'h9ABC; r2 = 16'hDEF0;
    n = 0;
    while (!rdy2 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    v2 = 1'b0;
    n = 0;
    while (!lrck2 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk_bit("r2_lrck_right_before_reset", lrck2, 1'b1);
    chk_bit("r2_buffer_full_before_reset", rdy2, 1'b0);
    #2 rst2 = 1'b1;
    #1;
    chk_bit("r2_rst_bclk", bclk2, 1'b0);
    chk_bit("r2_rst_lrck", lrck2, 1'b1);
    chk_bit("r2_rst_dat", dat2, 1'b0);
    chk_bit("r2_rst_ready", rdy2, 1'b1);
    chk_bit("r2_rst_underrun", ur2, 1'b0);
    @(negedge clk); rst2 = 1'b0;
    @(negedge clk);
    chk_bit("r2_edge1_bclk", bclk2, 1'b1);
    chk_bit("r2_edge1_lrck", lrck2, 1'b1);
    @(negedge clk);
    chk_bit("r2_edge2_bclk", bclk2, 1'b0);
    chk_bit("r2_edge2_lrck", lrck2, 1'b0);
    chk_bit("r2_edge2_underrun", ur2, 1'b0);
    chk_bit("r2_edge2_ready", rdy2, 1'b1);

    // Idle: zero frames, BCLK period 4, LRCK edges at 4, 132, 260.
    exp_q.push_back(mk_frame(1'b0, 16'h0, 16'h0));
    exp_q.push_back(mk_frame(1'b0, 16'h0, 16'h0));
    rst1 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk_bit($sformatf("idle_bclk_e%0d", e), bclk1, exp_b[3'(e - 1)]);
      chk_bit($sformatf("idle_lrck_e%0d", e), lrck1, exp_l[3'(e - 1)]);
    end
    cyc = 8;
    while (!lrck1 && cyc < 400) begin @(negedge clk); cyc++; end
    chk("lrck_rise_cycle", 65'(cyc), 65'(132));
    while (lrck1 && cyc < 400) begin @(negedge clk); cyc++; end
    chk("lrck_fall_cycle", 65'(cyc), 65'(260));
    wait_drain(600);

    // First pair accepted before the first load, then four streamed pairs.
    @(negedge clk); rst1 = 1'b1;
    @(negedge clk);
    v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      l1 = pl[i];
      r1 = pr[i];
      exp_q.push_back(mk_frame(1'b0, pl[i], pr[i]));
      if (i == 0) rst1 = 1'b0;
      n    = 0;
      prev = lrck1;
      while (!rdy1 && n < 400) begin prev = lrck1; @(negedge clk); n++; end
      if (i > 0) chk_bit($sformatf("ready_rise_at_load%0d", i), prev && !lrck1, 1'b1);
      @(posedge clk); @(negedge clk);
      chk_bit($sformatf("ready_low_after_accept%0d", i), rdy1, 1'b0);
    end
    v1 = 1'b0;

    // Withhold data for one frame: underrun plus an all-zero frame.
    wait_load("load_f4");
    exp_q.push_back(mk_frame(1'b1, 16'h0, 16'h0));
    wait_load("load_f5");
    exp_q.push_back(mk_frame(1'b0, 16'h4B1E, 16'hE1B4));
    l1 = 16'h4B1E; r1 = 16'hE1B4; v1 = 1'b1;
    @(posedge clk); @(negedge clk);
    v1 = 1'b0;
    chk_bit("ready_low_after_late_accept", rdy1, 1'b0);

    // Accept on the load edge itself: that frame is zero, the pair follows.
    wait_load("load_f6");
    exp_q.push_back(mk_frame(1'b1, 16'h0, 16'h0));
    exp_q.push_back(mk_frame(1'b0, 16'h0F0F, 16'hF00F));
    repeat (255) @(negedge clk);
    l1 = 16'h0F0F; r1 = 16'hF00F; v1 = 1'b1;
    prev = lrck1;
    @(posedge clk); @(negedge clk);
    v1 = 1'b0;
    chk_bit("accept_on_load_edge", prev && !lrck1, 1'b1);
    chk_bit("ready_low_after_load_accept", rdy1, 1'b0);
    wait_drain(700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
